rvvi_trace_driver: RTL and testbench
====================================

Name: rvvi_trace_driver

Overview:
- DUT-side producer of the RVVI trace stream for one hart with RETIRE=1.
- Accepts per-instruction retirement records from the core through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Emits one RVVI event per cycle, driving valid, order, insn, trap, debug_mode, pc_rdata, pc_wdata, mode, x_wb and x_wdata.
- Keeps a shadow X register file so that x_wdata always presents the full architectural GPR state.

Parameters:
- ILEN, 32, instruction length in bits.
- XLEN, 32, GPR and PC width in bits.
- DEPTH, 4, FIFO entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  interface clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  retirement record present.
- in_ready  output  1  FIFO can accept a record.
- in_insn  input  ILEN  instruction bit pattern.
- in_pc  input  XLEN  PC of the instruction.
- in_pc_next  input  XLEN  PC of the next instruction.
- in_trap  input  1  trap event, no retirement.
- in_debug  input  1  executed in debug mode.
- in_mode  input  2  privilege mode.
- in_rd  input  5  destination GPR index.
- in_rd_we  input  1  GPR write enable.
- in_rd_wdata  input  XLEN  GPR write value.
- out_hold  input  1  consumer stall; suppresses emission.
- valid  output  1  RVVI event valid, one cycle per event.
- order  output  64  event order count.
- insn  output  ILEN  RVVI insn.
- trap  output  1  RVVI trap.
- debug_mode  output  1  RVVI debug_mode.
- pc_rdata  output  XLEN  RVVI pc_rdata.
- pc_wdata  output  XLEN  RVVI pc_wdata.
- mode  output  2  RVVI mode.
- x_wb  output  32  one-hot GPR writeback flag.
- x_wdata  output  32*XLEN  shadow GPR file. Entry i occupies bits [i*XLEN +: XLEN].
- occupancy  output  $clog2(DEPTH)+1  current FIFO fill level.

Behaviour:
- Reset, checked on a clk edge with reset=1:
  - FIFO emptied; occupancy=0.
  - valid=0, order=0.
  - insn, trap, debug_mode, pc_rdata, pc_wdata, mode, x_wb all 0.
  - All 32 shadow registers 0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all buffered records without emitting them.
- Input handshake:
  - A record is pushed on an edge where in_valid && in_ready.
  - in_ready = (occupancy != DEPTH). It is a function of fill level only, so a same-cycle pop does not open a slot while full.
  - The core must hold all in_* stable while in_valid && !in_ready.
- Emission:
  - On an edge where occupancy>0 and out_hold=0: pop the head record into the output registers, set valid=1 and order=order+1.
  - On any other edge: valid=0 and all other outputs hold their values.
  - valid is therefore high for exactly one cycle per event.
  - Back-to-back events are emitted on consecutive cycles when records are queued.
- Latency: a record pushed at edge N appears with valid=1 after edge N+1 at the earliest. There is no bypass path.
- Order numbering:
  - The first event after reset has order=1.
  - Strictly +1 per emitted event: no gaps, no reuse, including trap events.
  - 64-bit wrap from 2^64-1 to 0 is permitted and not flagged.
- Register writeback, applied on the pop edge:
  - x_wb = one-hot(in_rd) when in_rd_we=1 && in_trap=0 && in_rd!=0; otherwise x_wb=0.
  - The shadow entry in_rd is updated with in_rd_wdata on the same edge, so x_wdata shows post-instruction state together with valid.
  - x0 always reads 0. Writes to x0 produce x_wb=0.
  - Trap events never update the shadow file and never set x_wb.
- Simultaneous push and pop:
  - Allowed whenever in_ready=1; occupancy is unchanged.
  - The FIFO must not corrupt the head when DEPTH-1 entries are present.
- out_hold=1 with occupancy=DEPTH: in_ready=0 and nothing is lost. Draining resumes the cycle after out_hold falls.

Test Plan:
- Reset, then push 3 records (pc 0x100/0x104/0x108, rd=5/6/7, wdata 0x11/0x22/0x33) in 3 consecutive cycles with out_hold=0:
  - valid high for 3 consecutive cycles starting 2 edges after the first push.
  - order 1,2,3.
  - x_wb 0x20, 0x40, 0x80.
  - x_wdata entries 5/6/7 = 0x11/0x22/0x33.
- Push with rd=0, in_rd_we=1, wdata 0xDEAD:
  - x_wb=0 and x_wdata entry 0 stays 0.
- Push a trap record (in_trap=1, rd=3, we=1, wdata 0x55) between two normal records:
  - order increments contiguously across it (e.g. 4,5,6).
  - The trap event has x_wb=0 and entry 3 is unchanged.
- Hold out_hold=1 and push DEPTH+2 records:
  - in_ready falls after DEPTH accepts; occupancy=DEPTH.
  - Release out_hold: all records emerge in order with no gaps, and the 2 stalled records are accepted once slots free.
- Push and pop every cycle for 20 cycles at occupancy 1:
  - occupancy constant at 1.
  - order increments every cycle.
  - pc_rdata sequence matches the input sequence.
- Assert reset with 3 records buffered:
  - Next cycle valid=0, order=0, occupancy=0, shadow file all 0.
  - The next pushed record is emitted with order=1.

Source files
------------

// File: rtl/rvvi_trace_driver.sv
// RVVI trace producer for a single hart (RETIRE=1). Retirement records are queued in a small FIFO
// and emitted one per cycle along with a shadow copy of the integer register file.
module rvvi_trace_driver #(
    parameter int unsigned ILEN  = 32,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ILEN-1:0]           in_insn,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [XLEN-1:0]           in_pc_next,
    input  logic                      in_trap,
    input  logic                      in_debug,
    input  logic [1:0]                in_mode,
    input  logic [4:0]                in_rd,
    input  logic                      in_rd_we,
    input  logic [XLEN-1:0]           in_rd_wdata,
    input  logic                      out_hold,
    output logic                      valid,
    output logic [63:0]               order,
    output logic [ILEN-1:0]           insn,
    output logic                      trap,
    output logic                      debug_mode,
    output logic [XLEN-1:0]           pc_rdata,
    output logic [XLEN-1:0]           pc_wdata,
    output logic [1:0]                mode,
    output logic [31:0]               x_wb,
    output logic [32*XLEN-1:0]        x_wdata,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic            trap;
        logic            debug;
        logic [1:0]      mode;
        logic [4:0]      rd;
        logic            rd_we;
        logic [XLEN-1:0] rd_wdata;
    } rec_t;

    rec_t            fifo_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] xreg_q [32];

    rec_t in_rec;
    rec_t head;
    logic push;
    logic pop;
    logic wb_en;

    // Ready depends on fill level only: a pop on the same edge never frees a slot while full.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (count_q != '0) && !out_hold;
    assign head      = fifo_q[rd_ptr_q];
    assign wb_en     = head.rd_we && !head.trap && (head.rd != 5'd0);
    assign occupancy = count_q;

    always_comb begin
        in_rec          = '0;
        in_rec.insn     = in_insn;
        in_rec.pc       = in_pc;
        in_rec.pc_next  = in_pc_next;
        in_rec.trap     = in_trap;
        in_rec.debug    = in_debug;
        in_rec.mode     = in_mode;
        in_rec.rd       = in_rd;
        in_rec.rd_we    = in_rd_we;
        in_rec.rd_wdata = in_rd_wdata;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid      <= 1'b0;
            order      <= '0;
            insn       <= '0;
            trap       <= 1'b0;
            debug_mode <= 1'b0;
            pc_rdata   <= '0;
            pc_wdata   <= '0;
            mode       <= '0;
            x_wb       <= '0;
        end else begin
            valid <= pop;
            if (pop) begin
                order      <= order + 64'd1;
                insn       <= head.insn;
                trap       <= head.trap;
                debug_mode <= head.debug;
                pc_rdata   <= head.pc;
                pc_wdata   <= head.pc_next;
                mode       <= head.mode;
                x_wb       <= wb_en ? (32'd1 << head.rd) : 32'd0;
            end
        end
    end

    // Entry 0 is never written, so x0 reads as zero from reset onward.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) xreg_q[i] <= '0;
        end else if (pop && wb_en) begin
            xreg_q[head.rd] <= head.rd_wdata;
        end
    end

    for (genvar i = 0; i < 32; i++) begin : g_xw
        assign x_wdata[i*XLEN +: XLEN] = xreg_q[i];
    end

endmodule

// File: tb/tb_rvvi_trace_driver.sv
// Bench for rvvi_trace_driver: directed scenarios plus random traffic, all checked against a
// queue-based reference model of the trace stream.
module tb_rvvi_trace_driver;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        trap;
        logic        dbg;
        logic [1:0]  mode;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wdata;
    } rec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_insn, in_pc, in_pc_next, in_rd_wdata;
    logic         in_trap, in_debug, in_rd_we;
    logic [1:0]   in_mode;
    logic [4:0]   in_rd;
    logic         out_hold;
    logic         valid;
    logic [63:0]  order;
    logic [31:0]  insn, pc_rdata, pc_wdata, x_wb;
    logic         trap, debug_mode;
    logic [1:0]   mode;
    logic [1023:0] x_wdata;
    logic [2:0]   occupancy;

    rvvi_trace_driver #(.ILEN(32), .XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_insn(in_insn), .in_pc(in_pc), .in_pc_next(in_pc_next),
        .in_trap(in_trap), .in_debug(in_debug), .in_mode(in_mode),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_rd_wdata(in_rd_wdata),
        .out_hold(out_hold),
        .valid(valid), .order(order), .insn(insn), .trap(trap), .debug_mode(debug_mode),
        .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .mode(mode), .x_wb(x_wb),
        .x_wdata(x_wdata), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending records plus the architectural view of the last event.
    rec_t        q[$];
    logic [31:0] sh[32];
    logic        e_valid;
    logic [63:0] e_order;
    rec_t        e_last;
    logic [31:0] e_xwb;
    rec_t        pend;
    bit          have_pend = 0;

    function automatic rec_t rand_rec();
        rec_t r;
        r.insn    = $urandom;
        r.pc      = $urandom & 32'hffff_fffc;
        r.pc_next = r.pc + 32'd4;
        r.trap    = ($urandom_range(7) == 0);
        r.dbg     = $urandom_range(1);
        r.mode    = 2'($urandom_range(3));
        r.rd      = 5'($urandom_range(31));
        r.we      = ($urandom_range(3) != 0);
        r.wdata   = $urandom;
        return r;
    endfunction

    function automatic rec_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                                input logic [31:0] wd, input logic tr);
        rec_t r;
        r = rand_rec();
        r.pc = pc; r.pc_next = pc + 32'd4; r.rd = rd; r.we = we; r.wdata = wd; r.trap = tr;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) sh[i] = '0;
        e_valid = 1'b0;
        e_order = '0;
        e_last  = '0;
        e_xwb   = '0;
    endtask

    task automatic compare_all();
        logic [1023:0] exw;
        for (int i = 0; i < 32; i++) exw[i*32 +: 32] = sh[i];
        check("valid", 1024'(valid), 1024'(e_valid));
        check("occupancy", 1024'(occupancy), 1024'(q.size()));
        check("order", 1024'(order), 1024'(e_order));
        check("insn", 1024'(insn), 1024'(e_last.insn));
        check("pc_rdata", 1024'(pc_rdata), 1024'(e_last.pc));
        check("pc_wdata", 1024'(pc_wdata), 1024'(e_last.pc_next));
        check("trap", 1024'(trap), 1024'(e_last.trap));
        check("debug_mode", 1024'(debug_mode), 1024'(e_last.dbg));
        check("mode", 1024'(mode), 1024'(e_last.mode));
        check("x_wb", 1024'(x_wb), 1024'(e_xwb));
        check("x_wdata", x_wdata, exw);
    endtask

    // One clock cycle: drive, step the model across the edge, then compare everything.
    task automatic step(input logic rst, input logic v, input logic hold, input rec_t r,
                        output bit acc);
        bit pop;
        rec_t f;
        reset = rst; in_valid = v; out_hold = hold;
        in_insn = r.insn; in_pc = r.pc; in_pc_next = r.pc_next; in_trap = r.trap;
        in_debug = r.dbg; in_mode = r.mode; in_rd = r.rd; in_rd_we = r.we; in_rd_wdata = r.wdata;
        #1;
        if (!rst) check("in_ready", 1024'(in_ready), 1024'(q.size() != DEPTH));
        acc = !rst && v && (q.size() != DEPTH);
        pop = !rst && (q.size() > 0) && !hold;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            e_valid = pop;
            if (pop) begin
                f = q.pop_front();
                e_order = e_order + 64'd1;
                e_last = f;
                if (f.we && !f.trap && f.rd != 0) begin
                    e_xwb = 32'd1 << f.rd;
                    sh[f.rd] = f.wdata;
                end else begin
                    e_xwb = '0;
                end
            end
            if (acc) q.push_back(r);
        end
        compare_all();
    endtask

    // Offer the pending record (held stable until accepted) or a fresh random one.
    task automatic drive(input logic v, input logic hold);
        bit acc;
        if (!have_pend) begin
            pend = rand_rec();
            have_pend = 1;
        end
        step(1'b0, v, hold, pend, acc);
        if (v && acc) have_pend = 0;
    endtask

    task automatic push_rec(input rec_t r, input logic hold);
        pend = r;
        have_pend = 1;
        drive(1'b1, hold);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    initial begin
        bit acc;
        model_reset();
        #2;
        step(1'b1, 1'b0, 1'b0, '0, acc);
        step(1'b1, 1'b0, 1'b0, '0, acc);
        idle(1);

        push_rec(mk(32'h100, 5'd5, 1'b1, 32'h11, 1'b0), 1'b0);
        push_rec(mk(32'h104, 5'd6, 1'b1, 32'h22, 1'b0), 1'b0);
        push_rec(mk(32'h108, 5'd7, 1'b1, 32'h33, 1'b0), 1'b0);
        idle(3);
        check("x5", 1024'(x_wdata[5*32 +: 32]), 1024'(32'h11));
        check("x7", 1024'(x_wdata[7*32 +: 32]), 1024'(32'h33));

        push_rec(mk(32'h10c, 5'd0, 1'b1, 32'hdead, 1'b0), 1'b0);
        idle(2);
        check("x0", 1024'(x_wdata[31:0]), 1024'(0));

        push_rec(mk(32'h110, 5'd8, 1'b1, 32'h1, 1'b0), 1'b0);
        push_rec(mk(32'h114, 5'd3, 1'b1, 32'h55, 1'b1), 1'b0);
        push_rec(mk(32'h118, 5'd9, 1'b1, 32'h2, 1'b0), 1'b0);
        idle(3);
        check("x3_after_trap", 1024'(x_wdata[3*32 +: 32]), 1024'(0));
        check("order_after_trap", 1024'(order), 1024'(64'd7));

        // Fill under hold, then release while the extra records keep knocking.
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, 1'b1);
        check("full_occ", 1024'(occupancy), 1024'(DEPTH));
        check("full_ready", 1024'(in_ready), 1024'(0));
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
        idle(DEPTH + 3);

        // Steady state at occupancy 1: push and pop every cycle.
        drive(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0);
        idle(3);

        // Reset with records buffered discards them.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, acc);
        have_pend = 0;
        push_rec(rand_rec(), 1'b0);
        idle(2);
        check("order_after_reset", 1024'(order), 1024'(64'd1));

        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(3) != 0), 1'($urandom_range(3) == 0));
        idle(DEPTH + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
